ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: RAM word width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports wr_req_valid in 1, wr_req_ready out 1, wr_req_addr in ADDR_WIDTH, wr_req_data in DATA_WIDTH: write request channel.
REQ-006 SHALL have ports rd1_req_valid in 1, rd1_req_ready out 1, rd1_req_addr in ADDR_WIDTH: read request channel 1.
REQ-007 SHALL have ports rd1_rsp_valid out 1, rd1_rsp_ready in 1, rd1_rsp_data out DATA_WIDTH: read response channel 1.
REQ-008 SHALL have rd2_* ports identical to REQ-006/007 for channel 2.
REQ-009 SHALL have ports ram_write_en out 1, ram_write_addr out ADDR_WIDTH, ram_write_data out DATA_WIDTH: RAM write port drive.
REQ-010 SHALL have ports ram_read_addr1/ram_read_addr2 out ADDR_WIDTH, ram_read_data1/ram_read_data2 in DATA_WIDTH: RAM read ports; RAM returns data one cycle after the address edge, pre-write contents on a same-edge write.

Function
REQ-011 SHALL treat a transfer as accepted in a cycle where valid and ready are both 1 at the rising edge.
REQ-012 SHALL drive wr_req_ready from a register: 0 in reset, 1 from the first edge after rst_n deasserts.
REQ-013 SHALL drive ram_write_en = wr_req_valid & wr_req_ready, ram_write_addr = wr_req_addr, ram_write_data = wr_req_data, combinationally.
REQ-014 SHALL drive ram_read_addrN = rdN_req_addr combinationally, regardless of acceptance.
REQ-015 SHALL keep per read channel an in-flight flag (1 bit) set for the cycle after acceptance, and a 3-entry response FIFO with count 0..3.
REQ-016 SHALL drive rdN_req_ready = 1 iff registered (count + inflight) <= 2; no combinational path from rdN_rsp_ready.
REQ-017 SHALL, in the cycle after a read acceptance, push ram_read_dataN into the FIFO, unless forwarding applies (REQ-018).
REQ-018 SHALL forward: if a read on channel N and a write are accepted at the same edge with equal addresses, the pushed word SHALL be the accepted wr_req_data, not ram_read_dataN.
REQ-019 SHALL drive rdN_rsp_valid = (count != 0) and rdN_rsp_data = FIFO head; pop on rsp acceptance; responses in request order.
REQ-020 SHALL support simultaneous push and pop with count unchanged; sustained 1 read/cycle/channel with rsp_ready held 1.
REQ-021 SHALL hold rdN_rsp_data stable while rdN_rsp_valid=1 and rdN_rsp_ready=0.
REQ-022 SHALL operate channels 1 and 2 independently; both may read the same address at the same edge, each forwarding per REQ-018.
REQ-023 SHALL make latency request-accept to rsp_valid exactly 2 cycles when the FIFO is empty.

Reset
REQ-024 SHALL on rst_n=0 clear both FIFOs (count 0), both in-flight flags, forwarding registers and wr_req_ready, immediately and asynchronously.
REQ-025 SHALL output during reset: rdN_rsp_valid=0, rdN_req_ready=1 (count+inflight=0), wr_req_ready=0, ram_write_en=0.
REQ-026 SHALL discard in-flight and buffered responses on reset mid-operation; RAM contents are not affected.

Structure
REQ-027 SHALL place the FIFO depth constant (3) and default ADDR_WIDTH/DATA_WIDTH in shared package ram_ctrl_pkg.
REQ-028 SHALL implement the response buffer as sub-module rsp_fifo (push/pop/count/head), instantiated once per read channel.
REQ-029 SHALL contain no RAM storage; it connects to the existing 1-write/2-read RAM block.

Verification
REQ-030 SHALL cover: write 0x5 := 0xDEAD, later rd1 0x5 with rsp_ready=1 -> rd1_rsp_data=0xDEAD exactly 2 cycles after acceptance.
REQ-031 SHALL cover: RAM[0x9]=0x1111, same-edge write 0x9 := 0x2222 and rd1+rd2 of 0x9 -> both responses 0x2222.
REQ-032 SHALL cover: rd2_rsp_ready=0, issue reads continuously -> exactly 3 accepted, rd2_req_ready=0, head data stable; release -> 3 responses in order.
REQ-033 SHALL cover: 100 back-to-back reads per channel, rsp_ready=1 -> req_ready never drops, 100 in-order responses each.
REQ-034 SHALL cover: rst_n low with 2 buffered + 1 in-flight -> rsp_valid=0 same cycle, no stale response after release.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_ctrl_pkg
// Description : Shared constants and types for the RAM access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int FIFO_DEPTH     = 3;
    localparam int CNT_WIDTH      = 2;
    localparam int NUM_RD_CH      = 2;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // Modulo-FIFO_DEPTH pointer advance (depth is not a power of two)
    function automatic cnt_t ptr_inc(input cnt_t p);
        return (p == cnt_t'(FIFO_DEPTH - 1)) ? '0 : p + cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rsp_fifo
// Description : 3-entry read-response FIFO with push/pop, count and head.
// Revision    : 1.0 - initial release
// ============================================================================
module rsp_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output cnt_t                  o_count,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    cnt_t                  r_wr_ptr;
    cnt_t                  r_rd_ptr;
    cnt_t                  r_count;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != cnt_t'(FIFO_DEPTH)) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_ctrl
// Description : One-write/two-read RAM front end with buffered read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic                  rd1_req_valid,
    output logic                  rd1_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd1_req_addr,
    output logic                  rd1_rsp_valid,
    input  logic                  rd1_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd1_rsp_data,
    input  logic                  rd2_req_valid,
    output logic                  rd2_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd2_req_addr,
    output logic                  rd2_rsp_valid,
    input  logic                  rd2_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd2_rsp_data,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr1,
    output logic [ADDR_WIDTH-1:0] ram_read_addr2,
    input  logic [DATA_WIDTH-1:0] ram_read_data1,
    input  logic [DATA_WIDTH-1:0] ram_read_data2
);

    logic                  r_wr_req_ready;
    logic                  w_wr_acc;

    logic [NUM_RD_CH-1:0]  w_rd_req_valid;
    logic [NUM_RD_CH-1:0]  w_rd_req_ready;
    logic [NUM_RD_CH-1:0]  w_rd_rsp_valid;
    logic [NUM_RD_CH-1:0]  w_rd_rsp_ready;
    logic [ADDR_WIDTH-1:0] w_rd_req_addr [NUM_RD_CH];
    logic [DATA_WIDTH-1:0] w_ram_rdata   [NUM_RD_CH];
    logic [DATA_WIDTH-1:0] w_rsp_data    [NUM_RD_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_req_ready <= 1'b0;
        end else begin
            r_wr_req_ready <= 1'b1;
        end
    end

    assign wr_req_ready   = r_wr_req_ready;
    assign w_wr_acc       = wr_req_valid & r_wr_req_ready;
    assign ram_write_en   = w_wr_acc;
    assign ram_write_addr = wr_req_addr;
    assign ram_write_data = wr_req_data;
    assign ram_read_addr1 = rd1_req_addr;
    assign ram_read_addr2 = rd2_req_addr;

    assign w_rd_req_valid   = {rd2_req_valid, rd1_req_valid};
    assign w_rd_rsp_ready   = {rd2_rsp_ready, rd1_rsp_ready};
    assign w_rd_req_addr[0] = rd1_req_addr;
    assign w_rd_req_addr[1] = rd2_req_addr;
    assign w_ram_rdata[0]   = ram_read_data1;
    assign w_ram_rdata[1]   = ram_read_data2;

    generate
        for (genvar g = 0; g < NUM_RD_CH; g++) begin : g_rd_ch
            logic                  r_inflight;
            logic                  r_fwd_hit;
            logic [DATA_WIDTH-1:0] r_fwd_data;
            logic                  w_req_acc;
            logic                  w_pop;
            logic [DATA_WIDTH-1:0] w_push_data;
            cnt_t                  w_count;
            logic [CNT_WIDTH:0]    w_occupancy;

            assign w_req_acc = w_rd_req_valid[g] & w_rd_req_ready[g];

            // RAM returns pre-write data on a colliding edge, so capture the write word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_inflight <= 1'b0;
                    r_fwd_hit  <= 1'b0;
                    r_fwd_data <= '0;
                end else begin
                    r_inflight <= w_req_acc;
                    r_fwd_hit  <= w_req_acc && w_wr_acc && (w_rd_req_addr[g] == wr_req_addr);
                    if (w_req_acc && w_wr_acc && (w_rd_req_addr[g] == wr_req_addr)) begin
                        r_fwd_data <= wr_req_data;
                    end
                end
            end

            assign w_push_data = r_fwd_hit ? r_fwd_data : w_ram_rdata[g];
            assign w_pop       = w_rd_rsp_valid[g] & w_rd_rsp_ready[g];

            rsp_fifo #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_rsp_fifo (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_push      (r_inflight),
                .i_push_data (w_push_data),
                .i_pop       (w_pop),
                .o_count     (w_count),
                .o_head      (w_rsp_data[g])
            );

            // Reserve a slot for the in-flight word so the FIFO can never overflow
            assign w_occupancy       = {1'b0, w_count} + {{CNT_WIDTH{1'b0}}, r_inflight};
            assign w_rd_req_ready[g] = (w_occupancy <= (CNT_WIDTH+1)'(FIFO_DEPTH - 1));
            assign w_rd_rsp_valid[g] = (w_count != '0);
        end
    endgenerate

    assign rd1_req_ready = w_rd_req_ready[0];
    assign rd2_req_ready = w_rd_req_ready[1];
    assign rd1_rsp_valid = w_rd_rsp_valid[0];
    assign rd2_rsp_valid = w_rd_rsp_valid[1];
    assign rd1_rsp_data  = w_rsp_data[0];
    assign rd2_rsp_data  = w_rsp_data[1];

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_ctrl
// Description : Directed self-checking bench with RAM model and response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_ctrl;

    localparam int AW = 6;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req_valid, wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          rd1_req_valid, rd1_req_ready, rd1_rsp_valid, rd1_rsp_ready;
    logic [AW-1:0] rd1_req_addr;
    logic [DW-1:0] rd1_rsp_data;
    logic          rd2_req_valid, rd2_req_ready, rd2_rsp_valid, rd2_rsp_ready;
    logic [AW-1:0] rd2_req_addr;
    logic [DW-1:0] rd2_rsp_data;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr, ram_read_addr1, ram_read_addr2;
    logic [DW-1:0] ram_write_data, ram_read_data1, ram_read_data2;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];
    int            checks   = 0;
    int            failures = 0;
    int            n_rsp1   = 0;
    int            n_rsp2   = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req_valid   (wr_req_valid),
        .wr_req_ready   (wr_req_ready),
        .wr_req_addr    (wr_req_addr),
        .wr_req_data    (wr_req_data),
        .rd1_req_valid  (rd1_req_valid),
        .rd1_req_ready  (rd1_req_ready),
        .rd1_req_addr   (rd1_req_addr),
        .rd1_rsp_valid  (rd1_rsp_valid),
        .rd1_rsp_ready  (rd1_rsp_ready),
        .rd1_rsp_data   (rd1_rsp_data),
        .rd2_req_valid  (rd2_req_valid),
        .rd2_req_ready  (rd2_req_ready),
        .rd2_req_addr   (rd2_req_addr),
        .rd2_rsp_valid  (rd2_rsp_valid),
        .rd2_rsp_ready  (rd2_rsp_ready),
        .rd2_rsp_data   (rd2_rsp_data),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_addr1 (ram_read_addr1),
        .ram_read_addr2 (ram_read_addr2),
        .ram_read_data1 (ram_read_data1),
        .ram_read_data2 (ram_read_data2)
    );

    // 1-write/2-read RAM: registered reads return pre-write contents
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        ram_read_data1 <= mem[ram_read_addr1];
        ram_read_data2 <= mem[ram_read_addr2];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req_valid = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        #1;
        chk("wr_en", ram_write_en, 1);
        step();
        wr_req_valid = 1'b0;
    endtask

    // Scoreboard: sample on the falling edge, push on request accept, pop on response accept
    task automatic monitor();
        logic          wacc;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q1.delete();
                q2.delete();
            end else begin
                wacc = wr_req_valid && wr_req_ready;
                if (rd1_rsp_valid && rd1_rsp_ready) begin
                    chk("rsp1_expected", q1.size() != 0, 1);
                    if (q1.size() != 0) begin
                        e = q1.pop_front();
                        chk("rsp1_data", rd1_rsp_data, e);
                    end
                    n_rsp1++;
                end
                if (rd2_rsp_valid && rd2_rsp_ready) begin
                    chk("rsp2_expected", q2.size() != 0, 1);
                    if (q2.size() != 0) begin
                        e = q2.pop_front();
                        chk("rsp2_data", rd2_rsp_data, e);
                    end
                    n_rsp2++;
                end
                if (rd1_req_valid && rd1_req_ready)
                    q1.push_back((wacc && wr_req_addr == rd1_req_addr) ? wr_req_data : mem[rd1_req_addr]);
                if (rd2_req_valid && rd2_req_ready)
                    q2.push_back((wacc && wr_req_addr == rd2_req_addr) ? wr_req_data : mem[rd2_req_addr]);
            end
        end
    endtask

    initial begin
        int            n_acc;
        int            base1;
        int            base2;
        int            hi_cnt;
        logic [AW-1:0] a;
        logic [DW-1:0] head;

        rst_n = 1'b0;
        wr_req_valid = 1'b1; wr_req_addr = '0; wr_req_data = '0;
        rd1_req_valid = 1'b0; rd1_req_addr = '0; rd1_rsp_ready = 1'b1;
        rd2_req_valid = 1'b0; rd2_req_addr = '0; rd2_rsp_ready = 1'b1;
        fork
            monitor();
        join_none

        step(); step();
        chk("rst_wr_ready",  wr_req_ready, 0);
        chk("rst_wr_en",     ram_write_en, 0);
        chk("rst_rd1_ready", rd1_req_ready, 1);
        chk("rst_rd2_ready", rd2_req_ready, 1);
        chk("rst_rd1_valid", rd1_rsp_valid, 0);
        chk("rst_rd2_valid", rd2_rsp_valid, 0);
        wr_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("wr_ready_before_edge", wr_req_ready, 0);
        step();
        chk("wr_ready_after_edge", wr_req_ready, 1);

        // Basic write then read with 2-cycle latency
        do_write(6'h05, 64'hDEAD);
        chk("wr_addr_passthru", ram_write_addr, 6'h05);
        step();
        rd1_req_valid = 1'b1;
        rd1_req_addr  = 6'h05;
        #1;
        chk("rd_addr1_passthru", ram_read_addr1, 6'h05);
        step();
        rd1_req_valid = 1'b0;
        chk("lat_valid_cyc1", rd1_rsp_valid, 0);
        step();
        chk("lat_valid_cyc2", rd1_rsp_valid, 1);
        chk("lat_data", rd1_rsp_data, 64'hDEAD);
        step();

        // Same-edge write forwarded to both read channels
        do_write(6'h09, 64'h1111);
        wr_req_valid = 1'b1; wr_req_addr = 6'h09; wr_req_data = 64'h2222;
        rd1_req_valid = 1'b1; rd1_req_addr = 6'h09;
        rd2_req_valid = 1'b1; rd2_req_addr = 6'h09;
        step();
        wr_req_valid = 1'b0; rd1_req_valid = 1'b0; rd2_req_valid = 1'b0;
        step();
        chk("fwd_rd1_valid", rd1_rsp_valid, 1);
        chk("fwd_rd1_data",  rd1_rsp_data, 64'h2222);
        chk("fwd_rd2_valid", rd2_rsp_valid, 1);
        chk("fwd_rd2_data",  rd2_rsp_data, 64'h2222);
        step();

        // Backpressure on channel 2: exactly three outstanding
        do_write(6'h10, 64'hA0);
        do_write(6'h11, 64'hA1);
        do_write(6'h12, 64'hA2);
        base2 = n_rsp2;
        rd2_rsp_ready = 1'b0;
        n_acc = 0;
        a = 6'h10;
        for (int i = 0; i < 8; i++) begin
            rd2_req_valid = 1'b1;
            rd2_req_addr  = a;
            #1;
            if (rd2_req_ready) begin
                n_acc++;
                a = a + 6'd1;
            end
            step();
        end
        chk("bp_accepted", n_acc, 3);
        chk("bp_req_ready", rd2_req_ready, 0);
        chk("bp_rsp_valid", rd2_rsp_valid, 1);
        head = rd2_rsp_data;
        chk("bp_head", head, 64'hA0);
        step(); step(); step();
        chk("bp_head_stable", rd2_rsp_data, head);
        rd2_req_valid = 1'b0;
        rd2_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("bp_drained", rd2_rsp_valid, 0);
        chk("bp_rsp_count", n_rsp2 - base2, 3);

        // 100 back-to-back reads per channel with concurrent random writes
        base1 = n_rsp1;
        base2 = n_rsp2;
        for (int i = 0; i < 100; i++) begin
            rd1_req_valid = 1'b1; rd1_req_addr = AW'(i);
            rd2_req_valid = 1'b1; rd2_req_addr = AW'(63 - (i % 64));
            wr_req_valid  = (i % 2) == 1;
            wr_req_addr   = AW'($urandom_range(0, 63));
            wr_req_data   = {$urandom, $urandom};
            #1;
            chk("b2b_rd1_ready", rd1_req_ready, 1);
            chk("b2b_rd2_ready", rd2_req_ready, 1);
            step();
        end
        rd1_req_valid = 1'b0; rd2_req_valid = 1'b0; wr_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("b2b_rsp1_count", n_rsp1 - base1, 100);
        chk("b2b_rsp2_count", n_rsp2 - base2, 100);

        // Reset with two buffered and one in-flight response
        rd1_rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            rd1_req_valid = 1'b1;
            rd1_req_addr  = AW'(i);
            step();
        end
        rd1_req_valid = 1'b0;
        chk("pre_rst_valid", rd1_rsp_valid, 1);
        #1;
        rst_n = 1'b0;
        wr_req_valid = 1'b1;
        #1;
        chk("mid_rst_valid", rd1_rsp_valid, 0);
        chk("mid_rst_ready", rd1_req_ready, 1);
        chk("mid_rst_wr_ready", wr_req_ready, 0);
        chk("mid_rst_wr_en", ram_write_en, 0);
        wr_req_valid = 1'b0;
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        rd1_rsp_ready = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rd1_rsp_valid) hi_cnt++;
        end
        chk("post_rst_no_stale", hi_cnt, 0);
        chk("post_rst_wr_ready", wr_req_ready, 1);
        chk("sb_q1_empty", q1.size(), 0);
        chk("sb_q2_empty", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
